// File: rtl/ddfs_sweep_controller.sv
// Frequency-sweep sequencer for the complex sinusoid DDFS control word.
// Steps start->stop with programmable step and dwell; single, sawtooth and triangle modes.
module ddfs_sweep_controller #(
  parameter int FREQ_WIDTH  = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [1:0]             i_mode,
  input  logic [FREQ_WIDTH-1:0]  i_start_freq,
  input  logic [FREQ_WIDTH-1:0]  i_stop_freq,
  input  logic [FREQ_WIDTH-1:0]  i_step,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  output logic [FREQ_WIDTH-1:0]  o_freq_control,
  output logic                   o_step_strobe,
  output logic                   o_direction,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [15:0]            o_pass_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);
  localparam logic [FREQ_WIDTH-1:0]  FREQ_ONE  = FREQ_WIDTH'(1);
  localparam logic [1:0]             MODE_SAW  = 2'd1;
  localparam logic [1:0]             MODE_TRI  = 2'd2;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [FREQ_WIDTH-1:0]  start_q, start_d;
  logic [FREQ_WIDTH-1:0]  stop_q, stop_d;
  logic [FREQ_WIDTH-1:0]  step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
  logic                   strobe_q, strobe_d;
  logic                   dir_q, dir_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [15:0]            pass_q, pass_d;

  logic [FREQ_WIDTH:0]    up_sum;
  logic [FREQ_WIDTH:0]    dn_diff;
  logic [FREQ_WIDTH-1:0]  up_next;
  logic [FREQ_WIDTH-1:0]  dn_next;
  logic [15:0]            pass_inc;

  // Both neighbours are computed from the current word; the extra bit catches carry/borrow.
  assign up_sum   = {1'b0, freq_q} + {1'b0, step_q};
  assign dn_diff  = {1'b0, freq_q} - {1'b0, step_q};
  assign up_next  = (up_sum[FREQ_WIDTH] || (up_sum[FREQ_WIDTH-1:0] >= stop_q)) ? stop_q : up_sum[FREQ_WIDTH-1:0];
  assign dn_next  = (dn_diff[FREQ_WIDTH] || (dn_diff[FREQ_WIDTH-1:0] <= start_q)) ? start_q : dn_diff[FREQ_WIDTH-1:0];
  assign pass_inc = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    freq_d   = freq_q;
    strobe_d = 1'b0;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (i_abort) begin
          busy_d = 1'b0;
        end else if (i_start) begin
          // A reversed range collapses to a single point; a zero step would never progress.
          mode_d   = i_mode;
          start_d  = i_start_freq;
          stop_d   = (i_stop_freq <= i_start_freq) ? i_start_freq : i_stop_freq;
          step_d   = (i_step == {FREQ_WIDTH{1'b0}}) ? FREQ_ONE : i_step;
          dwell_d  = (i_dwell == {DWELL_WIDTH{1'b0}}) ? DWELL_ONE : i_dwell;
          cnt_d    = (i_dwell == {DWELL_WIDTH{1'b0}}) ? DWELL_ONE : i_dwell;
          freq_d   = i_start_freq;
          strobe_d = 1'b1;
          busy_d   = 1'b1;
          dir_d    = 1'b0;
          pass_d   = 16'd0;
          state_d  = ST_UP;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_UP: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q != DWELL_ONE) begin
          cnt_d = cnt_q - DWELL_ONE;
        end else begin
          cnt_d = dwell_q;
          if (freq_q != stop_q) begin
            freq_d   = up_next;
            strobe_d = 1'b1;
          end else begin
            pass_d = pass_inc;
            case (mode_q)
              MODE_SAW: begin
                freq_d   = start_q;
                strobe_d = 1'b1;
              end
              MODE_TRI: begin
                state_d  = ST_DOWN;
                dir_d    = 1'b1;
                freq_d   = dn_next;
                strobe_d = 1'b1;
              end
              default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end
      end
      ST_DOWN: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q != DWELL_ONE) begin
          cnt_d = cnt_q - DWELL_ONE;
        end else begin
          cnt_d    = dwell_q;
          strobe_d = 1'b1;
          if (freq_q != start_q) begin
            freq_d = dn_next;
          end else begin
            pass_d  = pass_inc;
            state_d = ST_UP;
            dir_d   = 1'b0;
            freq_d  = up_next;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, configuration and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= 2'd0;
      start_q  <= {FREQ_WIDTH{1'b0}};
      stop_q   <= {FREQ_WIDTH{1'b0}};
      step_q   <= {FREQ_WIDTH{1'b0}};
      dwell_q  <= {DWELL_WIDTH{1'b0}};
      cnt_q    <= {DWELL_WIDTH{1'b0}};
      freq_q   <= {FREQ_WIDTH{1'b0}};
      strobe_q <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      freq_q   <= freq_d;
      strobe_q <= strobe_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign o_freq_control = freq_q;
  assign o_step_strobe  = strobe_q;
  assign o_direction    = dir_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_pass_count   = pass_q;

endmodule

// File: tb/tb_ddfs_sweep_controller.sv
// Self-checking bench for ddfs_sweep_controller: directed table, hand sequences and
// randomized traffic against a point-list reference model.
module tb_ddfs_sweep_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] sf = 32'd0, spf = 32'd0, stp = 32'd0;
  logic [15:0] dw = 16'd0;
  logic [31:0] o_freq;
  logic        o_strobe, o_dir, o_busy, o_done;
  logic [15:0] o_pass;

  ddfs_sweep_controller #(.FREQ_WIDTH(32), .DWELL_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_start_freq(sf), .i_stop_freq(spf), .i_step(stp), .i_dwell(dw),
    .o_freq_control(o_freq), .o_step_strobe(o_strobe), .o_direction(o_dir),
    .o_busy(o_busy), .o_done(o_done), .o_pass_count(o_pass)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the sweep is a walk over precomputed ascending/descending point lists.
  logic [31:0] m_freq = 32'd0;
  bit          m_strobe = 1'b0, m_dir = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int          m_pass = 0;
  logic [31:0] up_l[$], dn_l[$], seg[$];
  int          pos = 0, rem = 0, m_dw = 1;
  logic [1:0]  m_mode = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_freq = 32'd0; m_strobe = 1'b0; m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_pass = 0; pos = 0; rem = 0; seg.delete();
  endtask

  task automatic build_lists();
    longint s, e, st, v;
    s  = longint'(sf);
    e  = (spf <= sf) ? longint'(sf) : longint'(spf);
    st = (stp == 32'd0) ? 64'sd1 : longint'(stp);
    up_l.delete(); dn_l.delete();
    v = s;
    forever begin
      up_l.push_back(v[31:0]);
      if (v == e) break;
      v = (v + st >= e) ? e : v + st;
    end
    v = e;
    forever begin
      dn_l.push_back(v[31:0]);
      if (v == s) break;
      v = (v - st <= s) ? s : v - st;
    end
  endtask

  // After a turnaround the shared end point is not repeated, unless the list is a single point.
  task automatic load_tail(input bit use_dn);
    seg.delete();
    if (use_dn) begin
      if (dn_l.size() == 1) seg.push_back(dn_l[0]);
      else for (int i = 1; i < dn_l.size(); i++) seg.push_back(dn_l[i]);
    end else begin
      if (up_l.size() == 1) seg.push_back(up_l[0]);
      else for (int i = 1; i < up_l.size(); i++) seg.push_back(up_l[i]);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_strobe = 1'b0;
      m_done   = 1'b0;
      if (abort) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          m_mode = mode;
          m_dw   = (dw == 16'd0) ? 1 : int'(dw);
          build_lists();
          seg = up_l;
          pos = 0; m_freq = seg[0]; m_strobe = 1'b1; m_busy = 1'b1;
          m_dir = 1'b0; m_pass = 0; rem = m_dw;
        end
      end else if (rem > 1) begin
        rem--;
      end else begin
        rem = m_dw;
        if (pos < seg.size() - 1) begin
          pos++; m_freq = seg[pos]; m_strobe = 1'b1;
        end else begin
          if (m_pass < 65535) m_pass++;
          if (m_mode == 2'd1) begin
            seg = up_l; pos = 0; m_freq = seg[0]; m_strobe = 1'b1;
          end else if (m_mode == 2'd2) begin
            load_tail(!m_dir);
            m_dir = !m_dir; pos = 0; m_freq = seg[0]; m_strobe = 1'b1;
          end else begin
            m_busy = 1'b0; m_done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("freq", o_freq, m_freq);
    chk("strobe", o_strobe, m_strobe);
    chk("dir", o_dir, m_dir);
    chk("busy", o_busy, m_busy);
    chk("done", o_done, m_done);
    chk("pass", o_pass, m_pass);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cfg(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] s, input logic [15:0] d);
    mode = md; sf = a; spf = b; stp = s; dw = d;
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [31:0] a, b, s;
    logic [15:0] d;
    int          exp_cycles;
    int          exp_strobes;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vt[5];
  int tri_f[12] = '{0, 0, 10, 10, 20, 20, 10, 10, 0, 0, 10, 10};
  int tri_d[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int tri_p[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
  int saw_f[7]  = '{5, 6, 7, 5, 6, 7, 5};
  int saw_p[7]  = '{0, 0, 0, 1, 1, 1, 2};

  initial begin
    int n, s;
    bit found;
    vt[0] = '{2'd0, 32'd100, 32'd130, 32'd10, 16'd3, 12, 4, 32'd130};
    vt[1] = '{2'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 16'd1, 2, 2, 32'hFFFFFFFF};
    vt[2] = '{2'd3, 32'd50, 32'd40, 32'd7, 16'd2, 2, 1, 32'd50};
    vt[3] = '{2'd0, 32'd10, 32'd13, 32'd0, 16'd0, 4, 4, 32'd13};
    vt[4] = '{2'd0, 32'd0, 32'd25, 32'd10, 16'd1, 4, 4, 32'd25};

    // Reset state
    tick(); tick();
    chk("rst_freq", o_freq, 64'd0);
    chk("rst_busy", o_busy, 64'd0);
    rst = 1'b0;
    tick();

    // Single-sweep table
    for (int v = 0; v < 5; v++) begin
      cfg(vt[v].md, vt[v].a, vt[v].b, vt[v].s, vt[v].d);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      s = int'(o_strobe);
      for (int k = 0; k < 2000; k++) begin
        tick();
        n++;
        s += int'(o_strobe);
        if (o_done) break;
      end
      chk("tbl_cycles", n, vt[v].exp_cycles);
      chk("tbl_strobes", s, vt[v].exp_strobes);
      chk("tbl_final", o_freq, vt[v].exp_final);
      chk("tbl_pass", o_pass, 64'd1);
      tick();
      chk("tbl_hold", o_freq, vt[v].exp_final);
    end

    // Triangle 0..20 step 10 dwell 2
    cfg(2'd2, 32'd0, 32'd20, 32'd10, 16'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk("tri_freq", o_freq, tri_f[i]);
      chk("tri_dir", o_dir, tri_d[i]);
      chk("tri_pass", o_pass, tri_p[i]);
    end
    abort = 1'b1; tick(); abort = 1'b0;

    // Sawtooth 5..7 with dwell 0: a new value every cycle
    cfg(2'd1, 32'd5, 32'd7, 32'd1, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk("saw_freq", o_freq, saw_f[i]);
      chk("saw_strobe", o_strobe, 64'd1);
      chk("saw_pass", o_pass, saw_p[i]);
    end
    abort = 1'b1; tick(); abort = 1'b0;

    // Abort beats a simultaneous start; the next start is accepted with new config
    cfg(2'd0, 32'd100, 32'd130, 32'd10, 16'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_freq == 32'd110) begin found = 1'b1; break; end
    end
    chk("abort_reach110", found, 64'd1);
    cfg(2'd0, 32'd200, 32'd210, 32'd5, 16'd1);
    abort = 1'b1; start = 1'b1;
    tick();
    chk("abort_busy", o_busy, 64'd0);
    chk("abort_freq", o_freq, 64'd110);
    chk("abort_done", o_done, 64'd0);
    abort = 1'b0;
    tick();
    start = 1'b0;
    chk("restart_busy", o_busy, 64'd1);
    chk("restart_freq", o_freq, 64'd200);
    abort = 1'b1; tick(); abort = 1'b0;

    // Asynchronous reset between clock edges
    cfg(2'd2, 32'd100, 32'd130, 32'd10, 16'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_freq", o_freq, 64'd0);
    chk("arst_strobe", o_strobe, 64'd0);
    chk("arst_busy", o_busy, 64'd0);
    chk("arst_done", o_done, 64'd0);
    chk("arst_pass", o_pass, 64'd0);
    chk("arst_dir", o_dir, 64'd0);
    model_reset();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      sf = $urandom;
      if ($urandom_range(0, 3) == 0) sf = 32'hFFFFFFFF - $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) begin
        spf = (sf > 32'd5) ? sf - $urandom_range(0, 5) : sf;
      end else begin
        longint t;
        t = longint'(sf) + longint'($urandom_range(0, 60));
        spf = (t > 64'sh0FFFFFFFF) ? 32'hFFFFFFFF : t[31:0];
      end
      stp   = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 15);
      dw    = 16'($urandom_range(0, 3));
      mode  = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 79) == 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
